// File: rtl/lisp_pkg.sv
// ---------------------------------------------------------------------------
// lisp_pkg
//   Shared types and constants for the lisp machine datapath.
//   - header_t      : the type tag stored in the first word of every heap cell
//   - NIL           : the null pointer (address 0 is never allocated)
//   - alloc_state_t : state encoding of the cons/number cell allocator
//   - CONS_CELL_WORDS / NUM_CELL_WORDS : cell footprints in memory words
//   - cellWords()   : footprint of a cell kind, 0 for kinds the allocator
//                     cannot build
// ---------------------------------------------------------------------------
package lisp_pkg;

  typedef enum logic [7:0] {
    TYPE_NUMBER    = 8'h00,
    TYPE_CONS      = 8'h01,
    TYPE_SYMBOL    = 8'h02,
    TYPE_FUNC_PRIM = 8'h03,
    TYPE_FUNC_USER = 8'h04
  } header_t;

  localparam logic [11:0] NIL = 12'h000;

  typedef enum logic [1:0] {
    AllocIdle,
    AllocCheck,
    AllocWrite,
    AllocDone
  } alloc_state_t;

  localparam int CONS_CELL_WORDS = 5;
  localparam int NUM_CELL_WORDS  = 2;

  // A zero footprint doubles as the "illegal kind" marker for the allocator.
  function automatic logic [2:0] cellWords(input header_t kind);
    logic [2:0] words;
    case (kind)
      TYPE_CONS:   words = 3'(CONS_CELL_WORDS);
      TYPE_NUMBER: words = 3'(NUM_CELL_WORDS);
      default:     words = 3'd0;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/cons_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// cons_alloc_ctrl
//   Bump allocator for NUMBER and CONS cells in the shared 4K x 8 memory.
//   Takes one request at a time, checks it fits below HEAP_LIMIT, writes the
//   cell one word per granted beat and returns the cell base address.
//
// Parameters
//   HEAP_BASE   first allocatable address (0 is NIL, 1..F reserved)
//   HEAP_LIMIT  last allocatable address, inclusive
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_kind/num/car/cdr       cell kind and payload, latched at accept
//   resp_valid/addr/err        one-cycle completion pulse with base or NIL
//   mem_req/addr/wdata/gnt     write port to the memory arbiter
//   free_ptr                   next free address
//
// Build option
//   ALLOC_STATS_EN  adds saturating alloc_count (successes) and err_count
//                   (error responses) outputs, both bumped in the Done cycle.
// ---------------------------------------------------------------------------
module cons_alloc_ctrl
  import lisp_pkg::*;
#(
  parameter logic [11:0] HEAP_BASE  = 12'h010,
  parameter logic [11:0] HEAP_LIMIT = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_kind,
  input  logic [7:0]  req_num,
  input  logic [11:0] req_car,
  input  logic [11:0] req_cdr,
  output logic        resp_valid,
  output logic [11:0] resp_addr,
  output logic        resp_err,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_gnt,
`ifdef ALLOC_STATS_EN
  output logic [15:0] alloc_count,
  output logic [7:0]  err_count,
`endif
  output logic [11:0] free_ptr
);

  alloc_state_t state_q, state_d;
  logic [2:0]   beat_q, beat_d;
  logic [12:0]  free_q, free_d;
  header_t      kind_q, kind_d;
  logic [7:0]   num_q, num_d;
  logic [11:0]  car_q, car_d;
  logic [11:0]  cdr_q, cdr_d;
  logic         err_q, err_d;

  logic [2:0]   cellSize;
  logic [12:0]  lastAddr;
  logic         kindLegal;
  logic [7:0]   cellWord;

  // The free pointer is 13 bits wide so that an exact fit at 12'hFFF leaves
  // 13'h1000 behind, which every later check correctly treats as full.
  assign cellSize  = cellWords(kind_q);
  assign kindLegal = (cellSize != 3'd0);
  assign lastAddr  = free_q + 13'(cellSize) - 13'd1;

  // Word-select mux: the cell image is generated from the latched request
  // rather than stored, so only the current beat's word exists at any time.
  always_comb begin
    cellWord = kind_q;
    case (beat_q)
      3'd0:    cellWord = kind_q;
      3'd1:    cellWord = (kind_q == TYPE_NUMBER) ? num_q : {4'h0, car_q[11:8]};
      3'd2:    cellWord = car_q[7:0];
      3'd3:    cellWord = {4'h0, cdr_q[11:8]};
      3'd4:    cellWord = cdr_q[7:0];
      default: cellWord = kind_q;
    endcase
  end

  // State and datapath registers. Reset abandons any partially written cell
  // and rewinds the heap to its base.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= AllocIdle;
      beat_q  <= 3'd0;
      free_q  <= {1'b0, HEAP_BASE};
      kind_q  <= TYPE_NUMBER;
      num_q   <= 8'h00;
      car_q   <= NIL;
      cdr_q   <= NIL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      free_q  <= free_d;
      kind_q  <= kind_d;
      num_q   <= num_d;
      car_q   <= car_d;
      cdr_q   <= cdr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. Request fields are captured only on accept; the beat
  // counter moves only when the arbiter grants the current write.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    free_d  = free_q;
    kind_d  = kind_q;
    num_d   = num_q;
    car_d   = car_q;
    cdr_d   = cdr_q;
    err_d   = err_q;

    case (state_q)
      AllocIdle: begin
        if (req_valid) begin
          kind_d  = header_t'(req_kind);
          num_d   = req_num;
          car_d   = req_car;
          cdr_d   = req_cdr;
          beat_d  = 3'd0;
          err_d   = 1'b0;
          state_d = AllocCheck;
        end
      end

      AllocCheck: begin
        if (!kindLegal || (lastAddr > {1'b0, HEAP_LIMIT})) begin
          err_d   = 1'b1;
          state_d = AllocDone;
        end else begin
          state_d = AllocWrite;
        end
      end

      AllocWrite: begin
        if (mem_gnt) begin
          if (beat_q == (cellSize - 3'd1)) begin
            state_d = AllocDone;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end

      AllocDone: begin
        if (!err_q) begin
          free_d = free_q + 13'(cellSize);
        end
        state_d = AllocIdle;
      end

      default: state_d = AllocIdle;
    endcase
  end

  // Outputs are decoded from state so they are quiet (zero / NIL) outside the
  // states that drive them. Ready is also masked while reset is asserted.
  always_comb begin
    req_ready  = rst_n && (state_q == AllocIdle);
    mem_req    = 1'b0;
    mem_addr   = 12'h000;
    mem_wdata  = 8'h00;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_addr  = NIL;

    if (state_q == AllocWrite) begin
      mem_req   = 1'b1;
      mem_addr  = free_q[11:0] + {9'd0, beat_q};
      mem_wdata = cellWord;
    end

    if (state_q == AllocDone) begin
      resp_valid = 1'b1;
      resp_err   = err_q;
      resp_addr  = err_q ? NIL : free_q[11:0];
    end
  end

  assign free_ptr = free_q[11:0];

`ifdef ALLOC_STATS_EN
  logic [15:0] allocCount_q, allocCount_d;
  logic [7:0]  errCount_q, errCount_d;

  // Saturating statistics, bumped once per response in the Done cycle.
  always_comb begin
    allocCount_d = allocCount_q;
    errCount_d   = errCount_q;
    if (state_q == AllocDone) begin
      if (err_q) begin
        if (errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
      end else begin
        if (allocCount_q != 16'hFFFF) allocCount_d = allocCount_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      allocCount_q <= 16'h0000;
      errCount_q   <= 8'h00;
    end else begin
      allocCount_q <= allocCount_d;
      errCount_q   <= errCount_d;
    end
  end

  assign alloc_count = allocCount_q;
  assign err_count   = errCount_q;
`endif

endmodule

// File: tb/tb_cons_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cons_alloc_ctrl
//   Directed bench for cons_alloc_ctrl. Two instances share the request
//   inputs: dutA uses the full heap, dutB a tiny heap ending at 12'h014 to
//   reach overflow and exact-fit cases cheaply. A scoreboard holds expected
//   memory writes and responses; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_cons_alloc_ctrl;

  logic        clk;
  logic        rstA, rstB;
  logic        sel;
  logic        reqValid, gnt;
  logic [7:0]  kind, num;
  logic [11:0] car, cdr;

  logic        reqValidA, reqValidB;
  logic        readyA, readyB, respValidA, respValidB, respErrA, respErrB;
  logic        memReqA, memReqB;
  logic [11:0] respAddrA, respAddrB, memAddrA, memAddrB, freeA_o, freeB_o;
  logic [7:0]  memWdataA, memWdataB;
`ifdef ALLOC_STATS_EN
  logic [15:0] allocCountA, allocCountB;
  logic [7:0]  errCountA, errCountB;
`endif

  assign reqValidA = reqValid & ~sel;
  assign reqValidB = reqValid & sel;

  cons_alloc_ctrl dutA (
    .clk(clk), .rst_n(rstA), .req_valid(reqValidA), .req_ready(readyA),
    .req_kind(kind), .req_num(num), .req_car(car), .req_cdr(cdr),
    .resp_valid(respValidA), .resp_addr(respAddrA), .resp_err(respErrA),
    .mem_req(memReqA), .mem_addr(memAddrA), .mem_wdata(memWdataA), .mem_gnt(gnt),
`ifdef ALLOC_STATS_EN
    .alloc_count(allocCountA), .err_count(errCountA),
`endif
    .free_ptr(freeA_o)
  );

  cons_alloc_ctrl #(.HEAP_LIMIT(12'h014)) dutB (
    .clk(clk), .rst_n(rstB), .req_valid(reqValidB), .req_ready(readyB),
    .req_kind(kind), .req_num(num), .req_car(car), .req_cdr(cdr),
    .resp_valid(respValidB), .resp_addr(respAddrB), .resp_err(respErrB),
    .mem_req(memReqB), .mem_addr(memAddrB), .mem_wdata(memWdataB), .mem_gnt(gnt),
`ifdef ALLOC_STATS_EN
    .alloc_count(allocCountB), .err_count(errCountB),
`endif
    .free_ptr(freeB_o)
  );

  // Selected-instance view used by the monitor and the checks.
  logic        sRst, sReady, sRespValid, sRespErr, sMemReq;
  logic [11:0] sRespAddr, sMemAddr, sFree;
  logic [7:0]  sMemWdata;
  assign sRst       = sel ? rstB       : rstA;
  assign sReady     = sel ? readyB     : readyA;
  assign sRespValid = sel ? respValidB : respValidA;
  assign sRespErr   = sel ? respErrB   : respErrA;
  assign sRespAddr  = sel ? respAddrB  : respAddrA;
  assign sMemReq    = sel ? memReqB    : memReqA;
  assign sMemAddr   = sel ? memAddrB   : memAddrA;
  assign sMemWdata  = sel ? memWdataB  : memWdataA;
  assign sFree      = sel ? freeB_o    : freeA_o;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [11:0] addr;
    logic        err;
    int          acceptAt;
    int          lat;
  } rsp_t;

  wr_t  memQ[$];
  rsp_t respQ[$];

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int beatsSeen = 0;
  logic [11:0] expFreeA, expFreeB;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: a beat commits on the upcoming edge when mem_req && mem_gnt.
  always @(negedge clk) begin
    if (sRst === 1'b1) begin
      if (sMemReq && gnt) begin
        beatsSeen++;
        checks++;
        assert (memQ.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_write observed addr=%0h data=%0h expected none", sMemAddr, sMemWdata);
        end
        if (memQ.size() != 0) begin
          wr_t w;
          w = memQ.pop_front();
          checkOutput("mem_addr", 32'(sMemAddr), 32'(w.addr));
          checkOutput("mem_wdata", 32'(sMemWdata), 32'(w.data));
        end
      end
      if (sRespValid) begin
        checks++;
        assert (respQ.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_resp observed addr=%0h err=%0b expected none", sRespAddr, sRespErr);
        end
        if (respQ.size() != 0) begin
          rsp_t r;
          r = respQ.pop_front();
          checkOutput("resp_addr", 32'(sRespAddr), 32'(r.addr));
          checkOutput("resp_err", 32'(sRespErr), 32'(r.err));
          checkOutput("resp_latency", 32'(cycleCnt - r.acceptAt), 32'(r.lat));
        end
      end
    end
  end

  function automatic int cellSize(input logic [7:0] k);
    if (k == 8'h00) return 2;
    if (k == 8'h01) return 5;
    return 0;
  endfunction

  // Caller is always at posedge+1. Runs one full allocation on the selected
  // instance; stallLen>0 drops the grant for that many cycles at beat 2.
  task automatic applyStimulus(input logic [7:0] k, input logic [7:0] n,
                               input logic [11:0] a, input logic [11:0] d,
                               input logic expErr, input int stallLen);
    logic [11:0] base;
    int          size;
    bit          stalled;
    rsp_t        r;
    wr_t         hold;
    base = sel ? expFreeB : expFreeA;
    size = cellSize(k);
    if (!expErr) begin
      memQ.push_back('{base, k});
      if (size == 2) begin
        memQ.push_back('{base + 12'd1, n});
      end else begin
        memQ.push_back('{base + 12'd1, {4'h0, a[11:8]}});
        memQ.push_back('{base + 12'd2, a[7:0]});
        memQ.push_back('{base + 12'd3, {4'h0, d[11:8]}});
        memQ.push_back('{base + 12'd4, d[7:0]});
      end
    end
    checkOutput("ready_before_accept", 32'(sReady), 32'd1);
    kind = k; num = n; car = a; cdr = d;
    reqValid = 1'b1;
    beatsSeen = 0;
    @(posedge clk); #1;
    r.addr = expErr ? 12'h000 : base;
    r.err = expErr;
    r.acceptAt = cycleCnt;
    r.lat = expErr ? 1 : size + 1 + stallLen;
    respQ.push_back(r);
    reqValid = 1'b0;
    kind = ~k; num = ~n; car = ~a; cdr = ~d;
    checkOutput("ready_busy", 32'(sReady), 32'd0);
    checkOutput("mem_req_in_check", 32'(sMemReq), 32'd0);
    stalled = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (respQ.size() == 0) break;
      if (stallLen > 0 && !stalled && beatsSeen == 2 && memQ.size() != 0) begin
        stalled = 1;
        hold = memQ[0];
        gnt = 1'b0;
        for (int j = 0; j < stallLen; j++) begin
          @(posedge clk); #1;
          checkOutput("stall_mem_req", 32'(sMemReq), 32'd1);
          checkOutput("stall_mem_addr", 32'(sMemAddr), 32'(hold.addr));
          checkOutput("stall_mem_wdata", 32'(sMemWdata), 32'(hold.data));
        end
        gnt = 1'b1;
      end
    end
    checks++;
    assert (respQ.size() == 0) else begin
      errors++;
      $error("[TB] FAIL resp_timeout observed pending=%0d expected 0", respQ.size());
    end
    respQ.delete();
    memQ.delete();
    if (!expErr) begin
      if (sel) expFreeB = base + 12'(size);
      else     expFreeA = base + 12'(size);
    end
    checkOutput("ready_after_resp", 32'(sReady), 32'd1);
    checkOutput("free_ptr", 32'(sFree), 32'(sel ? expFreeB : expFreeA));
  endtask

  initial begin
    sel = 1'b0; rstA = 1'b0; rstB = 1'b0;
    reqValid = 1'b0; gnt = 1'b1;
    kind = 8'h00; num = 8'h00; car = 12'h000; cdr = 12'h000;
    expFreeA = 12'h010; expFreeB = 12'h010;

    // Reset state on dutA.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(sReady), 32'd0);
    checkOutput("rst_resp_valid", 32'(sRespValid), 32'd0);
    checkOutput("rst_resp_err", 32'(sRespErr), 32'd0);
    checkOutput("rst_resp_addr", 32'(sRespAddr), 32'h000);
    checkOutput("rst_mem_req", 32'(sMemReq), 32'd0);
    checkOutput("rst_mem_addr", 32'(sMemAddr), 32'h000);
    checkOutput("rst_mem_wdata", 32'(sMemWdata), 32'h00);
    checkOutput("rst_free_ptr", 32'(sFree), 32'h010);
    rstA = 1'b1; rstB = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_rst", 32'(sReady), 32'd1);

    // NUMBER 2A -> 0x010, then CONS (car=0x010, cdr=NIL) -> 0x012.
    applyStimulus(8'h00, 8'h2A, 12'h000, 12'h000, 1'b0, 0);
    checkOutput("free_after_num", 32'(sFree), 32'h012);
    applyStimulus(8'h01, 8'h00, 12'h010, 12'h000, 1'b0, 0);
    checkOutput("free_after_cons", 32'(sFree), 32'h017);

    // CONS with a 3-cycle grant stall at beat 2.
    applyStimulus(8'h01, 8'h00, 12'hABC, 12'h123, 1'b0, 3);
    checkOutput("free_after_stall", 32'(sFree), 32'h01C);

    // Reset during beat 2 abandons the cell and rewinds the heap.
    memQ.push_back('{12'h01C, 8'h01});
    memQ.push_back('{12'h01D, 8'h04});
    kind = 8'h01; car = 12'h456; cdr = 12'h789; num = 8'h00;
    reqValid = 1'b1;
    beatsSeen = 0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (beatsSeen >= 2) break;
      @(posedge clk); #1;
    end
    checkOutput("abort_reached_beat2", 32'(beatsSeen), 32'd2);
    rstA = 1'b0;
    memQ.delete();
    @(posedge clk); #1;
    checkOutput("abort_mem_req", 32'(sMemReq), 32'd0);
    checkOutput("abort_free_ptr", 32'(sFree), 32'h010);
    checkOutput("abort_ready_in_rst", 32'(sReady), 32'd0);
    rstA = 1'b1;
    expFreeA = 12'h010;
    @(posedge clk); #1;
    applyStimulus(8'h00, 8'h55, 12'h000, 12'h000, 1'b0, 0);
    checkOutput("realloc_free", 32'(sFree), 32'h012);

    // Illegal kind -> error, nothing written, pointer unchanged.
    applyStimulus(8'h03, 8'h00, 12'h000, 12'h000, 1'b1, 0);
    checkOutput("illegal_free", 32'(sFree), 32'h012);
`ifdef ALLOC_STATS_EN
    checkOutput("err_count", 32'(errCountA), 32'd1);
    checkOutput("alloc_count", 32'(allocCountA), 32'd1);
`endif

    // Small heap on dutB: overflow, fit after overflow, exact fit.
    sel = 1'b1;
    @(posedge clk); #1;
    applyStimulus(8'h00, 8'h11, 12'h000, 12'h000, 1'b0, 0);
    applyStimulus(8'h01, 8'h00, 12'h010, 12'h010, 1'b1, 0);
    checkOutput("overflow_free", 32'(sFree), 32'h012);
    applyStimulus(8'h00, 8'h22, 12'h000, 12'h000, 1'b0, 0);
    applyStimulus(8'h00, 8'h33, 12'h000, 12'h000, 1'b1, 0);
    checkOutput("full_free", 32'(sFree), 32'h014);
    rstB = 1'b0;
    @(posedge clk); #1;
    rstB = 1'b1;
    expFreeB = 12'h010;
    @(posedge clk); #1;
    applyStimulus(8'h01, 8'h00, 12'hFED, 12'h321, 1'b0, 0);
    checkOutput("exact_fit_free", 32'(sFree), 32'h015);
    applyStimulus(8'h00, 8'h44, 12'h000, 12'h000, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
